vertex_feeder: RTL and testbench
================================

Name: vertex_feeder

Overview:
- Upstream stage of the fp16 4x4 matrix-vector multiply pipeline.
- Holds the 16-word transform matrix, loaded by single-word writes.
- Assembles each incoming vertex from four 16-bit component beats, issues the matrix and vector to the multiply pipeline, and tracks results through its fixed latency.
- Buffers results in a small FIFO with valid/ready, because the multiply pipeline cannot stall. Issue is credit-limited so no result is ever dropped.

Parameters:
- LATENCY, 4: cycles from issue (a/b valid at multiplier inputs) to the result being valid on the multiply-pipeline output; must be >= 1.
- FIFO_DEPTH, 4: result FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- mat_we  in  1  matrix word write strobe
- mat_addr  in  4  word index, row-major (4*row+col)
- mat_data  in  16  fp16 matrix word
- mat_busy  out  1  high = matrix writes ignored
- comp_valid  in  1  vertex component beat valid
- comp_ready  out  1  component beat accepted when valid&ready
- comp_data  in  16  fp16 component, order x,y,z,w
- mm_a  out  256  matrix to multiply pipeline, packed [15:0][15:0]
- mm_b  out  64  vector to multiply pipeline, packed [3:0][15:0]
- mm_x  in  64  result from multiply pipeline, packed [3:0][15:0]
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  64  FIFO head, [3:0][15:0]

Behaviour:
- Reset values (async, rst=0):
  - matrix regs = identity (0x3C00 on diagonal, 0 elsewhere)
  - mm_b=0, beat counter=0, in-flight shift register=0, FIFO empty
  - res_valid=0, res_data=0, comp_ready=0 while in reset, mat_busy=0
  - Reset mid-operation discards all in-flight and buffered vertices.
- Matrix load:
  - A write takes effect at the clock edge when mat_we=1 and mat_busy=0.
  - mat_busy = (beat counter != 0) | (any in-flight bit set).
  - Writes while busy are ignored, not queued.
  - mm_a is driven directly from the matrix regs.
- Credits:
  - credits_used = in-flight count + FIFO occupancy.
  - comp_ready = 1 unless (beat counter==3 and credits_used >= FIFO_DEPTH). The final beat is the only beat that can stall.
- Vertex assembly:
  - Beat counter 0..3 advances on each accepted beat; component stored into lane[counter].
  - On the accepted beat 3, the full vector is registered into mm_b and issue=1 for that cycle. The counter wraps to 0.
  - mm_b holds its value between issues.
- States: COLLECT (counter 0..2), FINAL (counter==3, waiting on a credit). FINAL -> COLLECT on the accepted beat.
- In-flight tracking:
  - LATENCY-bit shift register, with issue shifted in at bit 0 each cycle.
  - When bit LATENCY-1 is 1, mm_x is written to the FIFO that cycle. The credit rule guarantees the FIFO is never full at that point.
- FIFO: standard wrap-around pointers.
  - Pop when res_valid & res_ready.
  - Push and pop in the same cycle: occupancy unchanged, order preserved.
  - Push into an empty FIFO: res_valid rises the next cycle (registered output).
- Simultaneous mat_we and a first component beat: the write is accepted (busy=0 at that edge) and the beat is accepted, so the vertex uses the new matrix.

Optional Feature:
- Macro: VERTEX_FEEDER_PERF_EN
- Defined: adds outputs perf_issued[31:0] (vertices issued) and perf_stall[31:0] (cycles in FINAL with comp_valid=1 and comp_ready=0). Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor the counters exist.

Decomposition:
- Shared package: fp16_t (logic [15:0]), vec4_t ([3:0] fp16_t), mat4_t ([15:0] fp16_t), FP16_ONE=16'h3C00, FP16_ZERO=16'h0000.
- One sub-module: vf_result_fifo (parameter DEPTH, width 64, push/pop/full/empty/count), used for the result buffer.

Test Plan:
- Reset, then one vertex with no matrix writes:
  - Stimulus: beats 0x3C00, 0x4000, 0x4200, 0x4400.
  - Response: mm_b = {0x4400,0x4200,0x4000,0x3C00} one cycle after the last beat.
  - With the multiply-pipeline model attached: res_data = {0x3C00,0x4200,0x4000,0x3C00} (w forced to 1.0 by the multiply stage), res_valid exactly LATENCY+1 cycles after the last beat.
- Matrix write:
  - Write addr 0 = 0x4000 (2.0), then send the same vertex.
  - Response: lane 0 = 0x4000. Attempt a write to addr 5 mid-vertex (beat 1): mat_busy=1 and reg 5 remains 0x3C00.
- Backpressure:
  - Hold res_ready=0 and stream 6 vertices back to back.
  - Response: exactly FIFO_DEPTH=4 vertices issued; comp_ready=0 at the beat 3 of vertex 5. Releasing res_ready drains 4 results in order, then vertices 5 and 6 complete.
- Simultaneous push/pop:
  - Keep res_ready=1 with continuous input.
  - Response: occupancy never exceeds 1, no result is dropped or duplicated, 1 vertex per 4 cycles sustained.
- Reset mid-flight:
  - Assert rst with 2 vertices in flight and 1 buffered.
  - Response: res_valid=0 immediately, matrix back to identity, no stale results after release.
- With VERTEX_FEEDER_PERF_EN defined, run the backpressure scenario:
  - Response: perf_issued=6, and perf_stall equals the counted stall cycles.

Source files
------------

// File: rtl/vertex_feeder_pkg.sv
// Shared types for the vertex feeder: fp16 words, 4-lane vectors, 4x4 matrices and FSM states.
package vertex_feeder_pkg;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [3:0] vec4_t;
    typedef fp16_t [15:0] mat4_t;

    localparam fp16_t FP16_ONE  = 16'h3C00;
    localparam fp16_t FP16_ZERO = 16'h0000;

    typedef enum logic {
        COLLECT = 1'b0,
        FINAL   = 1'b1
    } vf_state_t;

    function automatic mat4_t identity_mat();
        mat4_t m;
        for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? FP16_ONE : FP16_ZERO;
        return m;
    endfunction

endpackage

// File: rtl/vf_result_fifo.sv
// Wrap-around pointer FIFO holding multiply results until the consumer takes them.
module vf_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & ~full;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vertex_feeder.sv
// Matrix store, vertex beat assembly, credit-limited issue and result buffering for the fp16 4x4 MVM pipe.
// Optional perf counters are built when VERTEX_FEEDER_PERF_EN is defined.
//
// state   | meaning
// COLLECT | accepting beats x,y,z (beat counter 0..2)
// FINAL   | waiting to accept w; stalls until a result credit is free
module vertex_feeder
    import vertex_feeder_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mat_we,
    input  logic [3:0]   mat_addr,
    input  logic [15:0]  mat_data,
    output logic         mat_busy,
    input  logic         comp_valid,
    output logic         comp_ready,
    input  logic [15:0]  comp_data,
    output logic [255:0] mm_a,
    output logic [63:0]  mm_b,
    input  logic [63:0]  mm_x,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [63:0]  res_data
`ifdef VERTEX_FEEDER_PERF_EN
    ,
    output logic [31:0]  perf_issued,
    output logic [31:0]  perf_stall
`endif
);
    localparam int CW  = $clog2(LATENCY + FIFO_DEPTH + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    vf_state_t          state;
    logic [1:0]         beat_cnt;
    fp16_t [2:0]        lane_q;
    mat4_t              mat_q;
    logic [LATENCY-1:0] inflight;
    logic [CW-1:0]      inflight_cnt;
    logic [CW-1:0]      credits_used;
    logic [FCW-1:0]     fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               run_q;
    logic               accept;
    logic               issue;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++) inflight_cnt = inflight_cnt + CW'(inflight[i]);
    end

    assign credits_used = inflight_cnt + CW'(fifo_count);
    // fifo_full is implied by the credit count; kept as a direct guard on the last beat
    assign comp_ready   = run_q & ~((state == FINAL) & (fifo_full | (credits_used >= CW'(FIFO_DEPTH))));
    assign accept       = comp_valid & comp_ready;
    assign issue        = accept & (state == FINAL);
    assign mat_busy     = (beat_cnt != 2'd0) | (|inflight);
    assign mm_a         = mat_q;
    assign res_valid    = ~fifo_empty;

    // Ready is held off until the first clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= COLLECT;
            beat_cnt <= 2'd0;
            lane_q   <= '0;
            mm_b     <= '0;
        end else if (accept) begin
            case (state)
                COLLECT: begin
                    lane_q[beat_cnt] <= comp_data;
                    beat_cnt         <= beat_cnt + 2'd1;
                    if (beat_cnt == 2'd2) state <= FINAL;
                end
                FINAL: begin
                    mm_b     <= {comp_data, lane_q[2], lane_q[1], lane_q[0]};
                    beat_cnt <= 2'd0;
                    state    <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      mat_q           <= identity_mat();
        else if (mat_we && !mat_busy)  mat_q[mat_addr] <= mat_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight <= '0;
        else      inflight <= (inflight << 1) | LATENCY'(issue);
    end

    vf_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight[LATENCY-1]),
        .push_data (mm_x),
        .pop       (res_valid & res_ready),
        .pop_data  (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef VERTEX_FEEDER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            perf_issued <= perf_issued + {31'd0, issue};
            perf_stall  <= perf_stall + {31'd0, (state == FINAL) & comp_valid & ~comp_ready};
        end
    end
`endif

endmodule

// File: tb/tb_vertex_feeder.sv
// Directed bench for vertex_feeder with an fp16 multiply-pipeline model on mm_a/mm_b -> mm_x.
module tb_vertex_feeder;
    localparam int LAT    = 6;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mat_we = 1'b0;
    logic [3:0]   mat_addr = '0;
    logic [15:0]  mat_data = '0;
    logic         mat_busy;
    logic         comp_valid = 1'b0;
    logic         comp_ready;
    logic [15:0]  comp_data = '0;
    logic [255:0] mm_a;
    logic [63:0]  mm_b;
    logic [63:0]  mm_x;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [63:0]  res_data;
`ifdef VERTEX_FEEDER_PERF_EN
    logic [31:0]  perf_issued;
    logic [31:0]  perf_stall;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [255:0] tb_mat;
    logic [63:0]  exp_q [$];

    vertex_feeder #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mat_we(mat_we), .mat_addr(mat_addr), .mat_data(mat_data),
        .mat_busy(mat_busy), .comp_valid(comp_valid), .comp_ready(comp_ready), .comp_data(comp_data),
        .mm_a(mm_a), .mm_b(mm_b), .mm_x(mm_x), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
`ifdef VERTEX_FEEDER_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #(PERIOD/2) clk = ~clk;

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        e = int'(h[14:10]) - 15;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        int   e;
        int   man;
        real  a;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        man = int'((a - 1.0) * 1024.0);
        return {s, 5'(e + 15), 10'(man)};
    endfunction

    // rows x,y,z are M*v; w is forced to 1.0 by the multiply stage
    function automatic logic [63:0] mat_mul(input logic [255:0] a, input logic [63:0] b);
        logic [63:0] r;
        real acc;
        r = '0;
        for (int row = 0; row < 3; row++) begin
            acc = 0.0;
            for (int c = 0; c < 4; c++) acc += h2r(a[(4*row+c)*16 +: 16]) * h2r(b[c*16 +: 16]);
            r[row*16 +: 16] = r2h(acc);
        end
        r[63:48] = 16'h3C00;
        return r;
    endfunction

    function automatic logic [255:0] ident();
        logic [255:0] m;
        for (int i = 0; i < 16; i++) m[i*16 +: 16] = (i % 5 == 0) ? 16'h3C00 : 16'h0000;
        return m;
    endfunction

    function automatic logic [63:0] mk_vec(input int b);
        return {r2h(real'(b+3)), r2h(real'(b+2)), r2h(real'(b+1)), r2h(real'(b))};
    endfunction

    logic [63:0] mul_pipe [LAT-1];
    always @(posedge clk) begin
        mul_pipe[0] <= mat_mul(mm_a, mm_b);
        for (int k = 1; k < LAT-1; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
    assign mm_x = mul_pipe[LAT-2];

    task automatic send_beat(input logic [15:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        comp_valid = 1'b1;
        comp_data  = d;
        while (!comp_ready && waits < 200) begin @(negedge clk); waits++; end
        if (!comp_ready) begin
            vectors++; miscompares++;
            $display("FAIL beat_timeout: comp_ready still %0b after %0d cycles, want 1", comp_ready, waits);
        end
        @(posedge clk); #1;
        comp_valid = 1'b0;
    endtask

    task automatic send_vertex(input logic [63:0] v, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < 4; i++) begin send_beat(v[i*16 +: 16], w); waits += w; end
    endtask

    task automatic wait_res(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 100) begin @(posedge clk); #1; cycles++; end
        if (!res_valid) begin
            vectors++; miscompares++;
            $display("FAIL res_timeout: res_valid %0b after %0d cycles, want 1", res_valid, cycles);
        end
    endtask

    task automatic pop_res();
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic mat_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk); mat_we = 1'b1; mat_addr = a; mat_data = d;
        @(posedge clk); #1; mat_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; res_ready = 1'b0; comp_valid = 1'b0; mat_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        tb_mat = ident();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        vectors++; if (comp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_comp_ready: got %0b want 0", comp_ready); end
        vectors++; if (mat_busy !== 1'b0) begin miscompares++; $display("FAIL reset_mat_busy: got %0b want 0", mat_busy); end
        vectors++; if (res_data !== 64'h0) begin miscompares++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        vectors++; if (mm_b !== 64'h0) begin miscompares++; $display("FAIL reset_mm_b: got %h want 0", mm_b); end
        vectors++; if (mm_a !== ident()) begin miscompares++; $display("FAIL reset_mm_a: got %h want %h", mm_a, ident()); end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        tb_mat = ident();
        vectors++; if (comp_ready !== 1'b1) begin miscompares++; $display("FAIL idle_comp_ready: got %0b want 1", comp_ready); end
    endtask

    task automatic test_single_vertex();
        int w;
        int cyc;
        send_vertex(64'h4400_4200_4000_3C00, w);
        vectors++; if (mm_b !== 64'h4400_4200_4000_3C00) begin miscompares++; $display("FAIL single_mm_b: got %h want 4400420040003c00", mm_b); end
        vectors++; if (mat_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_inflight: got %0b want 1", mat_busy); end
        wait_res(cyc);
        vectors++; if (cyc != LAT) begin miscompares++; $display("FAIL single_latency: got %0d cycles want %0d", cyc, LAT); end
        vectors++; if (res_data !== 64'h3C00_4200_4000_3C00) begin miscompares++; $display("FAIL single_res_data: got %h want 3c00420040003c00", res_data); end
        pop_res();
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_after_pop: got %0b want 0", res_valid); end
        vectors++; if (mat_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_idle: got %0b want 0", mat_busy); end
    endtask

    task automatic test_matrix_write();
        int w;
        int cyc;
        mat_write(4'd0, 16'h4000);
        vectors++; if (mm_a[15:0] !== 16'h4000) begin miscompares++; $display("FAIL mat_write_0: got %h want 4000", mm_a[15:0]); end
        send_beat(16'h3C00, w);
        vectors++; if (mat_busy !== 1'b1) begin miscompares++; $display("FAIL mat_busy_mid: got %0b want 1", mat_busy); end
        mat_we = 1'b1; mat_addr = 4'd5; mat_data = 16'h4800;
        send_beat(16'h4000, w);
        mat_we = 1'b0;
        vectors++; if (mm_a[5*16 +: 16] !== 16'h3C00) begin miscompares++; $display("FAIL mat_busy_ignored: got %h want 3c00", mm_a[5*16 +: 16]); end
        send_beat(16'h4200, w);
        send_beat(16'h4400, w);
        wait_res(cyc);
        vectors++; if (res_data !== 64'h3C00_4200_4000_4000) begin miscompares++; $display("FAIL mat_scaled_res: got %h want 3c00420040004000", res_data); end
        pop_res();
        // matrix write coincident with the first beat of the next vertex
        @(negedge clk);
        mat_we = 1'b1; mat_addr = 4'd0; mat_data = 16'h3C00;
        comp_valid = 1'b1; comp_data = 16'h3C00;
        vectors++; if (mat_busy !== 1'b0 || comp_ready !== 1'b1) begin miscompares++; $display("FAIL simul_we_beat: busy %0b ready %0b want 0 1", mat_busy, comp_ready); end
        @(posedge clk); #1;
        mat_we = 1'b0; comp_valid = 1'b0;
        send_beat(16'h4000, w);
        send_beat(16'h4200, w);
        send_beat(16'h4400, w);
        wait_res(cyc);
        vectors++; if (res_data !== 64'h3C00_4200_4000_3C00) begin miscompares++; $display("FAIL simul_new_matrix: got %h want 3c00420040003c00", res_data); end
        pop_res();
    endtask

    task automatic test_backpressure();
        int w;
        int wt;
        int w5;
        int got;
        logic [63:0] v;
        logic [63:0] e;
        do_reset();
        wt = 0;
        for (int i = 1; i <= 4; i++) begin
            v = mk_vec(i); exp_q.push_back(mat_mul(tb_mat, v)); send_vertex(v, w); wt += w;
        end
        v = mk_vec(5); exp_q.push_back(mat_mul(tb_mat, v));
        for (int i = 0; i < 3; i++) begin send_beat(v[i*16 +: 16], w); wt += w; end
        vectors++; if (wt != 0) begin miscompares++; $display("FAIL bp_early_stall: got %0d wait cycles want 0", wt); end
        repeat (LAT+2) @(posedge clk);
        @(negedge clk);
        comp_valid = 1'b1; comp_data = v[63:48];
        vectors++; if (res_valid !== 1'b1 || mat_busy !== 1'b1) begin miscompares++; $display("FAIL bp_full_state: valid %0b busy %0b want 1 1", res_valid, mat_busy); end
`ifdef VERTEX_FEEDER_PERF_EN
        vectors++; if (perf_issued !== 32'd4) begin miscompares++; $display("FAIL bp_issued_4: got %0d want 4", perf_issued); end
`endif
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) res_ready = 1'b1;
            vectors++; if (comp_ready !== 1'b0) begin miscompares++; $display("FAIL bp_final_stall_%0d: comp_ready %0b want 0", k, comp_ready); end
        end
        got = 0;
        fork
            begin
                send_beat(v[63:48], w5);
                v = mk_vec(6); exp_q.push_back(mat_mul(tb_mat, v));
                send_vertex(v, w);
            end
            begin
                for (int n = 0; n < 100 && got < 6; n++) begin
                    if (res_valid) begin
                        e = exp_q.pop_front();
                        vectors++; if (res_data !== e) begin miscompares++; $display("FAIL bp_order_%0d: got %h want %h", got, res_data, e); end
                        got++;
                    end
                    if (got < 6) @(negedge clk);
                end
            end
        join
        @(posedge clk); #1; res_ready = 1'b0;
        vectors++; if (w5 != 0) begin miscompares++; $display("FAIL bp_release: beat waited %0d want 0", w5); end
        vectors++; if (got != 6) begin miscompares++; $display("FAIL bp_count: got %0d results want 6", got); end
`ifdef VERTEX_FEEDER_PERF_EN
        vectors++; if (perf_issued !== 32'd6) begin miscompares++; $display("FAIL perf_issued: got %0d want 6", perf_issued); end
        vectors++; if (perf_stall !== 32'd6) begin miscompares++; $display("FAIL perf_stall: got %0d want 6", perf_stall); end
`endif
    endtask

    task automatic test_back_to_back();
        int wt;
        int w;
        int got;
        int dup;
        longint t_prev;
        logic [63:0] v;
        logic [63:0] e;
        res_ready = 1'b1;
        wt = 0; got = 0; t_prev = 0;
        fork
            begin
                for (int i = 7; i <= 11; i++) begin
                    v = mk_vec(i); exp_q.push_back(mat_mul(tb_mat, v)); send_vertex(v, w); wt += w;
                end
            end
            begin
                for (int n = 0; n < 300 && got < 5; n++) begin
                    if (res_valid) begin
                        e = exp_q.pop_front();
                        vectors++; if (res_data !== e) begin miscompares++; $display("FAIL stream_data_%0d: got %h want %h", got, res_data, e); end
                        if (got > 0) begin
                            vectors++;
                            if ($time - t_prev != 4*PERIOD) begin miscompares++; $display("FAIL stream_spacing_%0d: got %0d want %0d", got, $time - t_prev, 4*PERIOD); end
                        end
                        t_prev = $time;
                        got++;
                    end
                    if (got < 5) @(negedge clk);
                end
            end
        join
        vectors++; if (wt != 0) begin miscompares++; $display("FAIL stream_stall: got %0d wait cycles want 0", wt); end
        vectors++; if (got != 5) begin miscompares++; $display("FAIL stream_count: got %0d want 5", got); end
        dup = 0;
        repeat (2*LAT) begin @(negedge clk); if (res_valid) dup++; end
        vectors++; if (dup != 0) begin miscompares++; $display("FAIL stream_dup: got %0d extra results want 0", dup); end
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_flight();
        int w;
        int cyc;
        int stale;
        res_ready = 1'b0;
        mat_write(4'd3, 16'h4000);
        send_vertex(mk_vec(1), w);
        wait_res(cyc);
        send_vertex(mk_vec(2), w);
        send_vertex(mk_vec(3), w);
        vectors++; if (res_valid !== 1'b1 || mat_busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_state: valid %0b busy %0b want 1 1", res_valid, mat_busy); end
        rst = 1'b0;
        #1;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %0b want 0", res_valid); end
        vectors++; if (mm_a !== ident()) begin miscompares++; $display("FAIL rst_mm_a: got %h want identity", mm_a); end
        vectors++; if (mm_b !== 64'h0) begin miscompares++; $display("FAIL rst_mm_b: got %h want 0", mm_b); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        exp_q.delete();
        tb_mat = ident();
        res_ready = 1'b1;
        stale = 0;
        repeat (3*LAT) begin @(negedge clk); if (res_valid) stale++; end
        vectors++; if (stale != 0) begin miscompares++; $display("FAIL rst_stale: got %0d results want 0", stale); end
        vectors++; if (mat_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", mat_busy); end
        res_ready = 1'b0;
    endtask

    initial begin
        tb_mat = ident();
        test_reset();
        test_single_vertex();
        test_matrix_write();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
